// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
//   Shared types and constants for the pipeline stall/flush sequencer:
//   sequencer state enum, legal parameter ranges, and the packed bundle of
//   the nine register-control outputs with their fixed patterns.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT      = 2'd0,
    ST_RUN       = 2'd1,
    ST_MUL_STALL = 2'd2
  } state_t;

  // Legal parameter ranges (the shared down-counter is 4 bits wide).
  localparam int INIT_CYCLES_MIN = 1;
  localparam int INIT_CYCLES_MAX = 15;
  localparam int MUL_CYCLES_MIN  = 2;
  localparam int MUL_CYCLES_MAX  = 15;

  // Enables and flushes for the PC and the four pipeline registers.
  // A flush drives the register's synchronous clear and overrides its enable.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
  } ctrl_t;

  //                                   pc ifid idex exmem memwb | ifid idex exmem memwb flush
  localparam ctrl_t FLUSH_ALL    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam ctrl_t FREEZE       = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  // Hold PC..ID/EX, inject a bubble into EX/MEM, let MEM/WB drain.
  localparam ctrl_t MUL_PAT      = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  // Redirect fetch and squash the two wrong-path instructions.
  localparam ctrl_t BRANCH_PAT   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  // Hold PC and IF/ID, insert a bubble into ID/EX.
  localparam ctrl_t LOAD_USE_PAT = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam ctrl_t RUN_PAT      = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// sat_counter
//   Saturating incrementer with asynchronous clear. Holds at all-ones.
//   Ports: clk, rst (async, active-high clear), inc (count this cycle),
//          count (current value).
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Stall/flush sequencer for the 5-stage pipeline. Drives enables and
//   synchronous clears of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
//   Ports:
//     clk_in, reset_in (async, active-high)
//     mem_busy_in, mul_start_in, branch_taken_in, load_use_hazard_in
//     *_en_out     register enables
//     *_flush_out  register synchronous clears (override enables)
//     busy_out     registered: high in INIT and MUL_STALL
//     stall_count_out  saturating count of non-INIT cycles with pc_en_out=0
//   Handshake: none; all outputs are combinational from registered state and
//   the current inputs and are consumed by the driven registers on the same edge.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES = 4,
  parameter int MUL_CYCLES  = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 mem_busy_in,
  input  logic                 mul_start_in,
  input  logic                 branch_taken_in,
  input  logic                 load_use_hazard_in,
  output logic                 pc_en_out,
  output logic                 if_id_en_out,
  output logic                 id_ex_en_out,
  output logic                 ex_mem_en_out,
  output logic                 mem_wb_en_out,
  output logic                 if_id_flush_out,
  output logic                 id_ex_flush_out,
  output logic                 ex_mem_flush_out,
  output logic                 mem_wb_flush_out,
  output logic                 busy_out,
  output logic [CNT_WIDTH-1:0] stall_count_out
);

  if (INIT_CYCLES < INIT_CYCLES_MIN || INIT_CYCLES > INIT_CYCLES_MAX ||
      MUL_CYCLES  < MUL_CYCLES_MIN  || MUL_CYCLES  > MUL_CYCLES_MAX) begin : g_param_err
    $error("pipeline_ctrl: INIT_CYCLES or MUL_CYCLES out of range");
  end

  localparam logic [3:0] INIT_LOAD = 4'(INIT_CYCLES - 1);
  // The start cycle in RUN is the first stall cycle, so MUL_STALL covers the rest.
  localparam logic [3:0] MUL_LOAD  = 4'(MUL_CYCLES - 2);

  state_t     state, next_state;
  logic [3:0] cnt, next_cnt;
  ctrl_t      ctrl;

  always_comb begin
    ctrl       = FLUSH_ALL;
    next_state = state;
    next_cnt   = cnt;
    case (state)
      ST_INIT: begin
        ctrl = FLUSH_ALL;
        if (cnt == 4'd0) next_state = ST_RUN;
        else             next_cnt   = cnt - 4'd1;
      end
      ST_RUN: begin
        if (mem_busy_in) begin
          ctrl = FREEZE;
        end else if (mul_start_in) begin
          // Multiply beats a simultaneous branch; EX re-presents the branch later.
          ctrl       = MUL_PAT;
          next_state = ST_MUL_STALL;
          next_cnt   = MUL_LOAD;
        end else if (branch_taken_in) begin
          // Beats load-use: the dependent instruction is squashed anyway.
          ctrl = BRANCH_PAT;
        end else if (load_use_hazard_in) begin
          ctrl = LOAD_USE_PAT;
        end else begin
          ctrl = RUN_PAT;
        end
      end
      ST_MUL_STALL: begin
        if (mem_busy_in) begin
          ctrl = FREEZE;
        end else begin
          ctrl = MUL_PAT;
          if (cnt == 4'd0) next_state = ST_RUN;
          else             next_cnt   = cnt - 4'd1;
        end
      end
      default: begin
        ctrl       = FLUSH_ALL;
        next_state = ST_INIT;
        next_cnt   = INIT_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state    <= ST_INIT;
      cnt      <= INIT_LOAD;
      busy_out <= 1'b1;
    end else begin
      state    <= next_state;
      cnt      <= next_cnt;
      busy_out <= (next_state != ST_RUN);
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk_in),
    .rst   (reset_in),
    .inc   (!ctrl.pc_en && (state != ST_INIT)),
    .count (stall_count_out)
  );

  assign pc_en_out        = ctrl.pc_en;
  assign if_id_en_out     = ctrl.if_id_en;
  assign id_ex_en_out     = ctrl.id_ex_en;
  assign ex_mem_en_out    = ctrl.ex_mem_en;
  assign mem_wb_en_out    = ctrl.mem_wb_en;
  assign if_id_flush_out  = ctrl.if_id_flush;
  assign id_ex_flush_out  = ctrl.id_ex_flush;
  assign ex_mem_flush_out = ctrl.ex_mem_flush;
  assign mem_wb_flush_out = ctrl.mem_wb_flush;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
//   Bench for pipeline_ctrl. Inputs change just after the falling edge,
//   outputs are compared 1 time unit later; the reference model advances on
//   the rising edge. Output vector order:
//   {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id, id_ex, ex_mem, mem_wb flushes}
module tb_pipeline_ctrl;

  localparam int INIT_CYCLES = 4;
  localparam int MUL_CYCLES  = 4;
  localparam int CNT_WIDTH   = 4;
  localparam int CNT_MAX     = (1 << CNT_WIDTH) - 1;

  localparam logic [8:0] P_FLUSH  = 9'b00000_1111;
  localparam logic [8:0] P_FREEZE = 9'b00000_0000;
  localparam logic [8:0] P_MUL    = 9'b00001_0010;
  localparam logic [8:0] P_BRANCH = 9'b11111_1100;
  localparam logic [8:0] P_LU     = 9'b00011_0100;
  localparam logic [8:0] P_RUN    = 9'b11111_0000;
  // Enable bits left open where a flush already clears the register.
  localparam logic [8:0] M_ALL    = 9'b11111_1111;
  localparam logic [8:0] M_MUL    = 9'b11011_1111;
  localparam logic [8:0] M_LU     = 9'b10111_1111;

  // ---- clock / reset ----
  logic clk_in = 1'b0;
  logic reset_in = 1'b1;
  logic mem_busy_in = 1'b0, mul_start_in = 1'b0, branch_taken_in = 1'b0, load_use_hazard_in = 1'b0;
  logic pc_en_out, if_id_en_out, id_ex_en_out, ex_mem_en_out, mem_wb_en_out;
  logic if_id_flush_out, id_ex_flush_out, ex_mem_flush_out, mem_wb_flush_out;
  logic busy_out;
  logic [CNT_WIDTH-1:0] stall_count_out;

  always #5 clk_in = ~clk_in;

  pipeline_ctrl #(
    .INIT_CYCLES(INIT_CYCLES), .MUL_CYCLES(MUL_CYCLES), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .mem_busy_in(mem_busy_in), .mul_start_in(mul_start_in),
    .branch_taken_in(branch_taken_in), .load_use_hazard_in(load_use_hazard_in),
    .pc_en_out(pc_en_out), .if_id_en_out(if_id_en_out), .id_ex_en_out(id_ex_en_out),
    .ex_mem_en_out(ex_mem_en_out), .mem_wb_en_out(mem_wb_en_out),
    .if_id_flush_out(if_id_flush_out), .id_ex_flush_out(id_ex_flush_out),
    .ex_mem_flush_out(ex_mem_flush_out), .mem_wb_flush_out(mem_wb_flush_out),
    .busy_out(busy_out), .stall_count_out(stall_count_out)
  );

  // ---- scoreboard / reference model ----
  logic [8:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int init_left = 0;   // flush cycles still owed after reset release
  int mul_left  = 0;   // multiply stall cycles still owed after the start cycle
  int model_cnt = 0;   // expected stall counter value

  function automatic logic [8:0] outs();
    return {pc_en_out, if_id_en_out, id_ex_en_out, ex_mem_en_out, mem_wb_en_out,
            if_id_flush_out, id_ex_flush_out, ex_mem_flush_out, mem_wb_flush_out};
  endfunction

  // ---- driver: one clock cycle, entered and left just after a falling edge ----
  task automatic step(input string name, input logic mb, input logic mul,
                      input logic br, input logic lu);
    logic [8:0] e, m, q;
    logic eb;
    mem_busy_in = mb; mul_start_in = mul; branch_taken_in = br; load_use_hazard_in = lu;
    #1;
    m = M_ALL;
    if (init_left > 0) begin
      e = P_FLUSH; eb = 1'b1;
    end else if (mul_left > 0) begin
      eb = 1'b1;
      if (mb) e = P_FREEZE;
      else begin e = P_MUL; m = M_MUL; end
    end else begin
      eb = 1'b0;
      if (mb)       e = P_FREEZE;
      else if (mul) begin e = P_MUL; m = M_MUL; end
      else if (br)  e = P_BRANCH;
      else if (lu)  begin e = P_LU; m = M_LU; end
      else          e = P_RUN;
    end
    exp_q.push_back(e);
    q = exp_q.pop_front();
    checks++;
    if ((outs() & m) !== (q & m)) begin
      errors++;
      $display("FAIL %s ctrl t=%0t actual=%b required=%b (mask %b)", name, $time, outs(), q, m);
    end
    checks++;
    if (busy_out !== eb) begin
      errors++;
      $display("FAIL %s busy t=%0t actual=%b required=%b", name, $time, busy_out, eb);
    end
    checks++;
    if (stall_count_out !== CNT_WIDTH'(model_cnt)) begin
      errors++;
      $display("FAIL %s stall_count t=%0t actual=%0d required=%0d", name, $time, stall_count_out, model_cnt);
    end
    @(posedge clk_in);
    if (init_left > 0) begin
      init_left--;
    end else begin
      if (!q[8] && model_cnt < CNT_MAX) model_cnt++;
      if (mul_left > 0) begin
        if (!mb) mul_left--;
      end else if (!mb && mul) begin
        mul_left = MUL_CYCLES - 1;
      end
    end
    @(negedge clk_in);
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (outs() !== P_FLUSH) begin
      errors++;
      $display("FAIL %s ctrl actual=%b required=%b", name, outs(), P_FLUSH);
    end
    checks++;
    if (busy_out !== 1'b1) begin
      errors++;
      $display("FAIL %s busy actual=%b required=1", name, busy_out);
    end
    checks++;
    if (stall_count_out !== '0) begin
      errors++;
      $display("FAIL %s stall_count actual=%0d required=0", name, stall_count_out);
    end
  endtask

  task automatic release_reset();
    reset_in = 1'b0;
    init_left = INIT_CYCLES; mul_left = 0; model_cnt = 0;
    exp_q.delete();
  endtask

  task automatic do_reset(input string name);
    reset_in = 1'b1;
    mem_busy_in = 1'b0; mul_start_in = 1'b0; branch_taken_in = 1'b0; load_use_hazard_in = 1'b0;
    #1;
    check_reset_outputs(name);
    @(negedge clk_in);
    release_reset();
  endtask

  task automatic run_init(input string name);
    repeat (INIT_CYCLES) step(name, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_count(input string name, input int required);
    checks++;
    if (stall_count_out !== CNT_WIDTH'(required)) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, stall_count_out, required);
    end
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    do_reset("reset_hold");
    run_init("reset_init");
    step("reset_run", 1'b0, 1'b0, 1'b0, 1'b0);
    check_count("reset_count", 0);
  endtask

  task automatic test_multiply();
    do_reset("mul_reset");
    run_init("mul_init");
    step("mul_start", 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (MUL_CYCLES - 1) step("mul_stall", 1'b0, 1'b0, 1'b0, 1'b0);
    step("mul_after", 1'b0, 1'b0, 1'b0, 1'b0);
    check_count("mul_count", 4);
  endtask

  task automatic test_mem_in_mul();
    do_reset("memmul_reset");
    run_init("memmul_init");
    step("memmul_start", 1'b0, 1'b1, 1'b0, 1'b0);
    step("memmul_s1",    1'b0, 1'b0, 1'b1, 1'b1);
    step("memmul_frz1",  1'b1, 1'b0, 1'b0, 1'b0);
    step("memmul_frz2",  1'b1, 1'b0, 1'b0, 1'b0);
    step("memmul_s2",    1'b0, 1'b1, 1'b0, 1'b0);
    step("memmul_s3",    1'b0, 1'b0, 1'b0, 1'b0);
    step("memmul_after", 1'b0, 1'b0, 1'b0, 1'b0);
    check_count("memmul_count", 6);
  endtask

  task automatic test_branch_load_use();
    do_reset("brlu_reset");
    run_init("brlu_init");
    step("brlu_both", 1'b0, 1'b0, 1'b1, 1'b1);
    step("mul_br",    1'b0, 1'b1, 1'b1, 1'b0);
    repeat (MUL_CYCLES - 1) step("mul_br_stall", 1'b0, 1'b0, 1'b0, 1'b0);
    step("brlu_after", 1'b0, 1'b0, 1'b1, 1'b0);
    check_count("brlu_count", 4);
  endtask

  task automatic test_saturation();
    do_reset("sat_reset");
    run_init("sat_init");
    repeat (20) step("sat_lu", 1'b0, 1'b0, 1'b0, 1'b1);
    check_count("sat_count", 15);
    step("sat_hold", 1'b1, 1'b0, 1'b0, 1'b0);
    check_count("sat_count_hold", 15);
  endtask

  task automatic test_reset_mid_mul();
    do_reset("rmm_reset");
    run_init("rmm_init");
    step("rmm_start", 1'b0, 1'b1, 1'b0, 1'b0);
    step("rmm_stall1", 1'b0, 1'b0, 1'b0, 1'b0);
    // Second MUL_STALL cycle: confirm the stall pattern, then reset mid-cycle.
    #1;
    checks++;
    if ((outs() & M_MUL) !== (P_MUL & M_MUL)) begin
      errors++;
      $display("FAIL rmm_stall2 actual=%b required=%b", outs(), P_MUL);
    end
    #2;
    reset_in = 1'b1;
    #1;
    check_reset_outputs("rmm_async");
    @(negedge clk_in);
    release_reset();
    repeat (INIT_CYCLES) step("rmm_reinit", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    step("rmm_run", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      do_reset("rand_reset");
      for (int c = 0; c < INIT_CYCLES + 30; c++) begin
        step("rand",
             1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 12),
             1'($urandom_range(0, 99) < 25), 1'($urandom_range(0, 99) < 25));
      end
    end
  endtask

  initial begin
    @(negedge clk_in);
    test_reset();
    test_multiply();
    test_mem_in_mul();
    test_branch_load_use();
    test_saturation();
    test_reset_mid_mul();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
